// File: rtl/zrle_encoder.sv
// Zero-run-length encoder: packs znz flags into DATA_W-bit MSB-first words for the EBPC stream.
// Define ZRLE_ENCODER_PROTOCOL_CHECK_EN to enable the sticky handshake checker on err_o.
module zrle_encoder #(
    parameter int unsigned DATA_W           = 8,
    parameter int unsigned LOG_MAX_ZRLE_LEN = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              znz_i,
    input  logic              last_i,
    input  logic              vld_i,
    output logic              rdy_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic              err_o
);
    // state | meaning
    // BITS  | no zero run open, literal '1' bits are appended directly
    // RUN   | zero run open, zcnt_q holds its length minus one
    // DRAIN | transmission ended, emitting remaining words until last_o
    localparam int unsigned L      = LOG_MAX_ZRLE_LEN;
    localparam int unsigned BUF_W  = 2 * DATA_W;
    localparam int unsigned FILL_W = $clog2(DATA_W) + 2;
    localparam int unsigned SYM_W  = L + 2;
    localparam logic [FILL_W-1:0] WORD   = FILL_W'(DATA_W);
    localparam logic [L-1:0]      ZC_SAT = L'((1 << L) - 2);

    typedef enum logic [1:0] {ST_BITS, ST_RUN, ST_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [L-1:0]      zcnt_q, zcnt_d;
    logic [SYM_W-1:0]  sym;
    logic [FILL_W-1:0] sym_len;
    logic [L-1:0]      zc_close;
    logic              run_open;
    logic              in_xfer, out_xfer;

    assign rdy_o    = (state_q != ST_DRAIN) && (fill_q < WORD);
    assign vld_o    = (state_q == ST_DRAIN) || (fill_q >= WORD);
    assign last_o   = (state_q == ST_DRAIN) && (fill_q <= WORD);
    assign data_o   = buf_q[BUF_W-1 -: DATA_W];
    assign in_xfer  = vld_i & rdy_o;
    assign out_xfer = vld_o & rdy_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_BITS;
            buf_q   <= '0;
            fill_q  <= '0;
            zcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            zcnt_q  <= zcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        fill_d   = fill_q;
        zcnt_d   = zcnt_q;
        sym      = '0;
        sym_len  = '0;
        run_open = 1'b0;
        zc_close = '0;
        if (out_xfer) begin
            if (last_o) begin
                buf_d   = '0;
                fill_d  = '0;
                zcnt_d  = '0;
                state_d = ST_BITS;
            end else begin
                buf_d  = buf_q << DATA_W;
                fill_d = (fill_q >= WORD) ? fill_q - WORD : '0;
            end
        end else if (in_xfer) begin
            case (state_q)
                ST_BITS: begin
                    if (znz_i) begin
                        sym     = {1'b1, {(SYM_W-1){1'b0}}};
                        sym_len = FILL_W'(1);
                    end else begin
                        zcnt_d   = '0;
                        run_open = 1'b1;
                        state_d  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (znz_i) begin
                        sym     = {1'b0, zcnt_q, 1'b1};
                        sym_len = FILL_W'(SYM_W);
                        state_d = ST_BITS;
                    end else if (zcnt_q == ZC_SAT) begin
                        sym     = {1'b0, {L{1'b1}}, 1'b0};
                        sym_len = FILL_W'(L + 1);
                        state_d = ST_BITS;
                    end else begin
                        zcnt_d   = zcnt_q + L'(1);
                        zc_close = zcnt_q + L'(1);
                        run_open = 1'b1;
                    end
                end
                default: ;
            endcase
            // A final flag never leaves a run open: close it in the same cycle.
            if (last_i) begin
                if (run_open) begin
                    sym     = {1'b0, zc_close, 1'b0};
                    sym_len = FILL_W'(L + 1);
                end
                state_d = ST_DRAIN;
            end
            buf_d  = buf_q | ((BUF_W'(sym) << (BUF_W - SYM_W)) >> fill_q);
            fill_d = fill_q + sym_len;
        end
    end

`ifdef ZRLE_ENCODER_PROTOCOL_CHECK_EN
    logic in_stall_q, znz_q, last_q, rdy_q, drain_q, err_q;
    logic viol;

    assign viol = (in_stall_q & (~vld_i | (znz_i != znz_q) | (last_i != last_q)))
                | (drain_q & (state_q == ST_DRAIN) & vld_o & rdy_q & ~rdy_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_stall_q <= 1'b0;
            znz_q      <= 1'b0;
            last_q     <= 1'b0;
            rdy_q      <= 1'b0;
            drain_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            in_stall_q <= vld_i & ~rdy_o;
            znz_q      <= znz_i;
            last_q     <= last_i;
            rdy_q      <= rdy_i;
            drain_q    <= (state_q == ST_DRAIN);
            if (viol) err_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i && viol) $error("zrle_encoder: handshake protocol violation");
    end
`endif

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_zrle_encoder.sv
// Self-checking bench for zrle_encoder: run-length model on queues plus directed literal cases.
module tb_zrle_encoder;
    localparam int DW   = 8;
    localparam int LL   = 4;
    localparam int MAXR = 1 << LL;

    logic          clk = 1'b0;
    logic          rst, znz, lsti, vldi, rdyo, lasto, vldo, rdyi, erro;
    logic [DW-1:0] datao;

    zrle_encoder #(.DATA_W(DW), .LOG_MAX_ZRLE_LEN(LL)) dut (
        .clk_i(clk), .rst_i(rst), .znz_i(znz), .last_i(lsti), .vld_i(vldi),
        .rdy_o(rdyo), .data_o(datao), .last_o(lasto), .vld_o(vldo), .rdy_i(rdyi),
        .err_o(erro)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit rdy_rand = 1'b0;

    bit            bitq[$];
    logic [DW-1:0] exp_d[$];
    bit            exp_l[$];
    logic [DW-1:0] act_d[$];
    bit            act_l[$];
    int            zrun = 0;

    bit            hold_prev = 1'b0;
    logic [DW-1:0] prev_d;
    logic          prev_l;

    function automatic void chk(string name, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic void emit_run(int n);
        bitq.push_back(1'b0);
        for (int i = LL - 1; i >= 0; i--) bitq.push_back(bit'(((n - 1) >> i) & 1));
    endfunction

    function automatic void pack(bit fin);
        logic [DW-1:0] w;
        while (bitq.size() >= DW) begin
            w = '0;
            for (int k = 0; k < DW; k++) w = {w[DW-2:0], bitq.pop_front()};
            exp_d.push_back(w);
            exp_l.push_back(1'b0);
        end
        if (fin) begin
            if (bitq.size() > 0) begin
                w = '0;
                for (int k = 0; k < DW; k++) w = {w[DW-2:0], (bitq.size() > 0) ? bitq.pop_front() : 1'b0};
                exp_d.push_back(w);
                exp_l.push_back(1'b0);
            end
            exp_l[exp_l.size() - 1] = 1'b1;
        end
    endfunction

    // Runs are cut into chunks of at most MAXR zeros; a chunk is emitted once it is complete.
    function automatic void model_accept(bit z, bit l);
        if (z) begin
            if (zrun > 0) emit_run(zrun);
            zrun = 0;
            bitq.push_back(1'b1);
        end else begin
            zrun++;
            if (zrun == MAXR) begin
                emit_run(MAXR);
                zrun = 0;
            end
        end
        if (l) begin
            if (zrun > 0) emit_run(zrun);
            zrun = 0;
        end
        pack(l);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            bitq.delete();
            exp_d.delete();
            exp_l.delete();
            zrun = 0;
            hold_prev = 1'b0;
        end else begin
            if (vldo && rdyo) chk("hs_exclusive", 1, 0);
            if (hold_prev) begin
                chk("hold_data", int'(datao), int'(prev_d));
                chk("hold_last", int'(lasto), int'(prev_l));
                chk("hold_vld", int'(vldo), 1);
            end
            if (vldi && rdyo) model_accept(znz, lsti);
            if (vldo && rdyi) begin
                act_d.push_back(datao);
                act_l.push_back(lasto);
                if (exp_d.size() == 0) begin
                    chk("unexpected_word", int'(datao), -1);
                end else begin
                    chk("word_data", int'(datao), int'(exp_d.pop_front()));
                    chk("word_last", int'(lasto), int'(exp_l.pop_front()));
                end
                if (lasto) done_cnt++;
            end
            hold_prev = vldo && !rdyi;
            prev_d = datao;
            prev_l = lasto;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rdy_rand) rdyi = ($urandom_range(0, 3) != 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(bit z, bit l, int gap);
        bit ok;
        vldi = 1'b0;
        repeat (gap) tick();
        vldi = 1'b1;
        znz  = z;
        lsti = l;
        ok   = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (rdyo) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("send_timeout", 0, 1);
        vldi = 1'b0;
        lsti = 1'b0;
    endtask

    task automatic wait_done(int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("done_timeout", done_cnt, target);
    endtask

    task automatic check_log1(string name, int d);
        chk({name, "_count"}, act_d.size(), 1);
        if (act_d.size() >= 1) begin
            chk({name, "_data"}, int'(act_d[0]), d);
            chk({name, "_last"}, int'(act_l[0]), 1);
        end
    endtask

    initial begin
        int tgt, n, pz;
        rst = 1'b1; vldi = 1'b0; znz = 1'b0; lsti = 1'b0; rdyi = 1'b1;
        repeat (2) tick();
        chk("rst_rdy", int'(rdyo), 1);
        chk("rst_vld", int'(vldo), 0);
        chk("rst_last", int'(lasto), 0);
        chk("rst_data", int'(datao), 0);
        chk("rst_err", int'(erro), 0);
        rst = 1'b0;
        tick();

        // 8 ones, last on the 8th
        act_d.delete(); act_l.delete(); tgt = done_cnt + 1;
        for (int i = 0; i < 8; i++) send(1'b1, i == 7, 0);
        wait_done(tgt);
        check_log1("ones8", 'hFF);
        tick();
        chk("ones8_rdy_after", int'(rdyo), 1);
        chk("ones8_vld_after", int'(vldo), 0);

        // 0,0,0,1(last)
        act_d.delete(); act_l.delete(); tgt = done_cnt + 1;
        send(1'b0, 1'b0, 0); send(1'b0, 1'b0, 1); send(1'b0, 1'b0, 0); send(1'b1, 1'b1, 0);
        wait_done(tgt);
        check_log1("run3", 'h14);

        // 16 zeros then 1(last): saturated run
        act_d.delete(); act_l.delete(); tgt = done_cnt + 1;
        for (int i = 0; i < 16; i++) send(1'b0, 1'b0, 0);
        send(1'b1, 1'b1, 0);
        wait_done(tgt);
        check_log1("sat16", 'h7C);

        // 1, 0(last): single-zero run closed by last
        act_d.delete(); act_l.delete(); tgt = done_cnt + 1;
        send(1'b1, 1'b0, 0); send(1'b0, 1'b1, 0);
        wait_done(tgt);
        check_log1("onezero", 'h80);

        // 16 ones with 5 cycles of output backpressure
        act_d.delete(); act_l.delete(); tgt = done_cnt + 1;
        rdyi = 1'b0;
        for (int i = 0; i < 8; i++) send(1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", int'(datao), 'hFF);
            chk("bp_rdy", int'(rdyo), 0);
            tick();
        end
        rdyi = 1'b1;
        for (int i = 0; i < 8; i++) send(1'b1, i == 7, 0);
        wait_done(tgt);
        chk("bp_count", act_d.size(), 2);
        if (act_d.size() == 2) begin
            chk("bp_w0", int'(act_d[0]), 'hFF);
            chk("bp_l0", int'(act_l[0]), 0);
            chk("bp_w1", int'(act_d[1]), 'hFF);
            chk("bp_l1", int'(act_l[1]), 1);
        end

        // reset in the middle of an open run
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        act_d.delete(); act_l.delete(); tgt = done_cnt + 1;
        send(1'b1, 1'b1, 0);
        wait_done(tgt);
        check_log1("rst_mid", 'h80);

        // randomized transmissions with random output backpressure
        rdy_rand = 1'b1;
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(1, 48);
            case ($urandom_range(0, 3))
                0: pz = 10;
                1: pz = 50;
                2: pz = 85;
                default: pz = 98;
            endcase
            tgt = done_cnt + 1;
            for (int i = 0; i < n; i++)
                send($urandom_range(0, 99) >= pz, i == n - 1, ($urandom_range(0, 3) == 0) ? 1 : 0);
            wait_done(tgt);
        end
        rdy_rand = 1'b0;
        rdyi = 1'b1;
        repeat (3) tick();
        chk("model_drained", exp_d.size(), 0);
        chk("err_idle", int'(erro), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/zrle_encoder.md
Name: zrle_encoder

Overview:
- Upstream counterpart of the ZRLE decoder in the EBPC stream path.
- Consumes one zero/non-zero (znz) flag per handshake and emits a packed zero-run-length bitstream in DATA_W-bit words, MSB first. The decoder consumes exactly this format.
- Symbols:
  - non-zero: single '1' bit.
  - run of n zeros (1 <= n <= 2^LOG_MAX_ZRLE_LEN): '0' followed by LOG_MAX_ZRLE_LEN bits holding n-1, MSB first.
- last_i ends a transmission: the final word is zero-padded and tagged with last_o.

Parameters:
- DATA_W, 8, output word width; must satisfy LOG_MAX_ZRLE_LEN+1 <= DATA_W.
- LOG_MAX_ZRLE_LEN, 4, run-length field width; MAX_ZRLE_LEN = 2^LOG_MAX_ZRLE_LEN.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- znz_i  in  1  input flag; 1 = non-zero, 0 = zero.
- last_i  in  1  marks the final flag of a transmission.
- vld_i  in  1  input valid.
- rdy_o  out  1  input ready.
- data_o  out  DATA_W  packed output word.
- last_o  out  1  final word of the transmission.
- vld_o  out  1  output valid.
- rdy_i  in  1  output ready.
- err_o  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- State registers:
  - buf_q: 2*DATA_W bits, MSB-aligned.
  - fill_q: LOG2(DATA_W)+2 bits.
  - zcnt_q: LOG_MAX_ZRLE_LEN bits.
  - state_q in {BITS, RUN, DRAIN}.
- Reset:
  - state=BITS; buf, fill, zcnt = 0.
  - vld_o=0, last_o=0, data_o=0, err_o=0.
  - rdy_o=1 (combinational from registers).
- Handshakes:
  - Input transfer: vld_i & rdy_o.
  - Output transfer: vld_o & rdy_i.
  - rdy_o = (state_q != DRAIN) & (fill_q < DATA_W). It does not depend on vld_i or rdy_i.
  - Outside DRAIN, vld_o = (fill_q >= DATA_W). Input and output transfers are therefore never in the same cycle.
- Output data:
  - data_o = buf_q[2*DATA_W-1:DATA_W], driven directly from registers.
  - On output transfer: buf <<= DATA_W; fill -= DATA_W, saturating at 0.
- Symbol appending: new bits are ORed into buf at position fill_q, MSB first. fill increases by the bit count. At most LOG_MAX_ZRLE_LEN+2 bits are appended per cycle, which fits because fill_q < DATA_W.
- BITS state (no open run), on input transfer:
  - znz=1: append '1'.
  - znz=0: zcnt=0, go to RUN; no bits appended.
- RUN state, on input transfer:
  - znz=1: append '0'+zcnt, then '1'; go to BITS.
  - znz=0 with zcnt==MAX_ZRLE_LEN-2: append '0'+(MAX_ZRLE_LEN-1), i.e. the run saturates; go to BITS.
  - znz=0 otherwise: zcnt+1.
- last_i accepted with a flag:
  - Process the flag as above.
  - Then close any still-open run: append '0'+zcnt (a single zero gives '0'+0).
  - Go to DRAIN. fill is always > 0 here.
- DRAIN state:
  - vld_o=1.
  - last_o = (fill_q <= DATA_W); unused low bits of the final word are 0.
  - On output transfer with last_o: buf, fill, zcnt = 0; go to BITS.
- Backpressure: data_o, vld_o and last_o hold stable while vld_o & ~rdy_i.
- Timing:
  - Latency from input transfer to the word becoming visible: 1 cycle.
  - Throughput: 1 flag/cycle, minus 1 stall cycle per emitted word.
- Reset mid-operation: all partial data is discarded immediately; there is no flush.

Optional Feature:
- Macro: ZRLE_ENCODER_PROTOCOL_CHECK_EN.
- Defined: err_o is set and held until reset on any of:
  - vld_i dropping while vld_i & ~rdy_o in the previous cycle;
  - znz_i or last_i changing under that same input stall;
  - rdy_i dropping while vld_o is held in DRAIN.
  - Simulation $error messages accompany each violation.
- Not defined: err_o tied to 0; no checker logic.

Test Plan (DATA_W=8, LOG_MAX_ZRLE_LEN=4):
- 8x znz=1, last on the 8th -> one word 0xFF with last_o=1; then rdy_o=1, state BITS.
- Flags 0,0,0,1(last) -> bits 0 0010 1 -> word 0x14, last_o=1.
- 16x zero then 1(last) -> saturated run 0 1111 on the 16th zero, then '1' -> 0x7C, last_o=1; zcnt never exceeds 14.
- Flags 1,0(last) -> '1' + '0 0000' -> 0x80, last_o=1.
- 16x one with rdy_i=0 for 5 cycles after the first vld_o -> data_o=0xFF held stable, rdy_o=0; then 0xFF, and 0xFF with last_o on the second word.
- rst_i pulse mid-run after 3 zeros, then 1(last) -> single word 0x80, last_o=1; no residue from before reset.
